// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline (ctrl_pipe).
// Holds the ALUOp encodings, the forward-select encodings, the per-stage
// control bundle, and a helper that applies the MEM-over-WB forwarding priority.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_RTYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // ALUOp is carried as raw bits so that the unused codes 01/10 pass through untouched.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    alu_src:   1'b0,
    alu_op:    ALU_ADD
  };

  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register (ID/EX, EX/MEM or MEM/WB).
// Ports: clk/rst (synchronous, active-high), load (capture enable),
// bubble (capture an empty slot), bundle/write_reg (next contents),
// bundle_q/write_reg_q (registered contents).
// With CTRL_PIPE_FORWARD_EN defined it also stores the source register fields (rs/rt).
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  stage_ctrl_t      bundle,
  input  logic [REG_W-1:0] write_reg,
`ifdef CTRL_PIPE_FORWARD_EN
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic [REG_W-1:0] rs_q,
  output logic [REG_W-1:0] rt_q,
`endif
  output stage_ctrl_t      bundle_q,
  output logic [REG_W-1:0] write_reg_q
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      bundle_q    <= STAGE_BUBBLE;
      write_reg_q <= '0;
`ifdef CTRL_PIPE_FORWARD_EN
      rs_q        <= '0;
      rt_q        <= '0;
`endif
    end else if (load) begin
      bundle_q    <= bundle;
      write_reg_q <= write_reg;
`ifdef CTRL_PIPE_FORWARD_EN
      rs_q        <= rs;
      rt_q        <= rt;
`endif
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline ID/EX -> EX/MEM -> MEM/WB with a retired-instruction count.
// Inputs: clk_i, rst_i (synchronous, active-high), valid_i, decoded controls
// (RegDst_i, ALUSrc_i, RegWrite_i, ALUOp_i), register fields (Rs_i, Rt_i, Rd_i),
// stall_i (bubble into EX; upstream holds), and flush_i (drop the ID instruction).
// Outputs: EX controls, MEM and WB write intent, retired_o.
// Build option: CTRL_PIPE_FORWARD_EN adds ForwardA_o/ForwardB_o (MEM has priority over WB).
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             RegDst_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [REG_W-1:0] Rs_i,
  input  logic [REG_W-1:0] Rt_i,
  input  logic [REG_W-1:0] Rd_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic             ex_ALUSrc_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic [REG_W-1:0] ex_WriteReg_o,
  output logic             mem_RegWrite_o,
  output logic [REG_W-1:0] mem_WriteReg_o,
  output logic             wb_RegWrite_o,
  output logic [REG_W-1:0] wb_WriteReg_o,
`ifdef CTRL_PIPE_FORWARD_EN
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
`endif
  output logic [31:0]      retired_o
);

  stage_ctrl_t      id_ctrl, ex_ctrl, mem_ctrl_d, mem_ctrl, wb_ctrl_d, wb_ctrl;
  logic [REG_W-1:0] id_wreg, ex_wreg, mem_wreg, wb_wreg;
  logic             id_bubble;
  logic [31:0]      retired;

  always_comb begin
    id_wreg           = RegDst_i ? Rd_i : Rt_i;
    id_ctrl           = STAGE_BUBBLE;
    id_ctrl.valid     = valid_i;
    // Writes to register 0 are dropped at capture.
    id_ctrl.reg_write = RegWrite_i && (id_wreg != '0);
    id_ctrl.alu_src   = ALUSrc_i;
    id_ctrl.alu_op    = ALUOp_i;
  end

  assign id_bubble = !valid_i || stall_i || flush_i;

  // ALU controls stop at EX; downstream stages carry only valid/RegWrite/WriteReg.
  always_comb begin
    mem_ctrl_d           = STAGE_BUBBLE;
    mem_ctrl_d.valid     = ex_ctrl.valid;
    mem_ctrl_d.reg_write = ex_ctrl.reg_write;
    wb_ctrl_d            = STAGE_BUBBLE;
    wb_ctrl_d.valid      = mem_ctrl.valid;
    wb_ctrl_d.reg_write  = mem_ctrl.reg_write;
  end

`ifdef CTRL_PIPE_FORWARD_EN
  logic [REG_W-1:0] ex_rs, ex_rt;
  logic [REG_W-1:0] unused_mem_rs, unused_mem_rt, unused_wb_rs, unused_wb_rt;
  logic             unused_src_bits;
  assign unused_src_bits = ^{unused_mem_rs, unused_mem_rt, unused_wb_rs, unused_wb_rt};
`else
  logic             unused_src_bits;
  assign unused_src_bits = ^{Rs_i, Rt_i};
`endif

  ctrl_stage_reg #(.REG_W(REG_W)) u_id_ex (
    .clk         (clk_i),
    .rst         (rst_i),
    .load        (1'b1),
    .bubble      (id_bubble),
    .bundle      (id_ctrl),
    .write_reg   (id_wreg),
`ifdef CTRL_PIPE_FORWARD_EN
    .rs          (Rs_i),
    .rt          (Rt_i),
    .rs_q        (ex_rs),
    .rt_q        (ex_rt),
`endif
    .bundle_q    (ex_ctrl),
    .write_reg_q (ex_wreg)
  );

  ctrl_stage_reg #(.REG_W(REG_W)) u_ex_mem (
    .clk         (clk_i),
    .rst         (rst_i),
    .load        (1'b1),
    .bubble      (1'b0),
    .bundle      (mem_ctrl_d),
    .write_reg   (ex_wreg),
`ifdef CTRL_PIPE_FORWARD_EN
    .rs          ('0),
    .rt          ('0),
    .rs_q        (unused_mem_rs),
    .rt_q        (unused_mem_rt),
`endif
    .bundle_q    (mem_ctrl),
    .write_reg_q (mem_wreg)
  );

  ctrl_stage_reg #(.REG_W(REG_W)) u_mem_wb (
    .clk         (clk_i),
    .rst         (rst_i),
    .load        (1'b1),
    .bubble      (1'b0),
    .bundle      (wb_ctrl_d),
    .write_reg   (mem_wreg),
`ifdef CTRL_PIPE_FORWARD_EN
    .rs          ('0),
    .rt          ('0),
    .rs_q        (unused_wb_rs),
    .rt_q        (unused_wb_rt),
`endif
    .bundle_q    (wb_ctrl),
    .write_reg_q (wb_wreg)
  );

  logic unused_stage_bits;
  assign unused_stage_bits = ^{mem_ctrl.alu_src, mem_ctrl.alu_op,
                               wb_ctrl.alu_src, wb_ctrl.alu_op, unused_src_bits};

  always_ff @(posedge clk_i) begin
    if (rst_i)              retired <= '0;
    else if (wb_ctrl.valid) retired <= retired + 32'd1;
  end

  assign ex_valid_o     = ex_ctrl.valid;
  assign ex_ALUSrc_o    = ex_ctrl.alu_src;
  assign ex_ALUOp_o     = ex_ctrl.alu_op;
  assign ex_WriteReg_o  = ex_wreg;
  assign mem_RegWrite_o = mem_ctrl.valid && mem_ctrl.reg_write;
  assign mem_WriteReg_o = mem_wreg;
  assign wb_RegWrite_o  = wb_ctrl.valid && wb_ctrl.reg_write;
  assign wb_WriteReg_o  = wb_wreg;
  assign retired_o      = retired;

`ifdef CTRL_PIPE_FORWARD_EN
  assign ForwardA_o = fwd_select(mem_RegWrite_o && (mem_WriteReg_o == ex_rs),
                                 wb_RegWrite_o  && (wb_WriteReg_o  == ex_rs));
  assign ForwardB_o = fwd_select(mem_RegWrite_o && (mem_WriteReg_o == ex_rt),
                                 wb_RegWrite_o  && (wb_WriteReg_o  == ex_rt));
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
`timescale 1ns/1ps
module tb_ctrl_pipe;

  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst_i, valid_i, RegDst_i, ALUSrc_i, RegWrite_i, stall_i, flush_i;
  logic [1:0]       ALUOp_i;
  logic [REG_W-1:0] Rs_i, Rt_i, Rd_i;
  logic             ex_valid_o, ex_ALUSrc_o, mem_RegWrite_o, wb_RegWrite_o;
  logic [1:0]       ex_ALUOp_o;
  logic [REG_W-1:0] ex_WriteReg_o, mem_WriteReg_o, wb_WriteReg_o;
  logic [31:0]      retired_o;
`ifdef CTRL_PIPE_FORWARD_EN
  logic [1:0]       ForwardA_o, ForwardB_o;
`endif

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .RegDst_i       (RegDst_i),
    .ALUSrc_i       (ALUSrc_i),
    .RegWrite_i     (RegWrite_i),
    .ALUOp_i        (ALUOp_i),
    .Rs_i           (Rs_i),
    .Rt_i           (Rt_i),
    .Rd_i           (Rd_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .ex_valid_o     (ex_valid_o),
    .ex_ALUSrc_o    (ex_ALUSrc_o),
    .ex_ALUOp_o     (ex_ALUOp_o),
    .ex_WriteReg_o  (ex_WriteReg_o),
    .mem_RegWrite_o (mem_RegWrite_o),
    .mem_WriteReg_o (mem_WriteReg_o),
    .wb_RegWrite_o  (wb_RegWrite_o),
    .wb_WriteReg_o  (wb_WriteReg_o),
`ifdef CTRL_PIPE_FORWARD_EN
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o),
`endif
    .retired_o      (retired_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One accepted instruction as it should appear in a given stage on cycle 'due'.
  typedef struct {
    int         due;
    logic       rw;
    logic [4:0] wreg;
    logic       asrc;
    logic [1:0] aop;
    logic [4:0] rs;
    logic [4:0] rt;
  } exp_t;

  exp_t        ex_q[$], mem_q[$], wb_q[$];
  int          checks = 0;
  int          misses = 0;
  logic [31:0] exp_retired = '0;
  bit          started = 0;
  bit          prev_rst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      misses++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] src, input logic mrw,
                                           input logic [4:0] mw, input logic wrw,
                                           input logic [4:0] ww);
    if (mrw && mw == src)      return 2'b10;
    else if (wrw && ww == src) return 2'b01;
    else                       return 2'b00;
  endfunction

  // Driver: presents one ID-stage cycle and records where the instruction should show up.
  task automatic issue(input bit rst, input bit v, input bit rdst, input bit asrc, input bit rw,
                       input logic [1:0] aop, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit st, input bit fl);
    exp_t e;
    int   k;
    k = cyc;
    rst_i = rst; valid_i = v; RegDst_i = rdst; ALUSrc_i = asrc; RegWrite_i = rw;
    ALUOp_i = aop; Rs_i = rs; Rt_i = rt; Rd_i = rd; stall_i = st; flush_i = fl;
    if (rst) begin
      for (int i = ex_q.size() - 1; i >= 0; i--)  if (ex_q[i].due > k)  ex_q.delete(i);
      for (int i = mem_q.size() - 1; i >= 0; i--) if (mem_q[i].due > k) mem_q.delete(i);
      for (int i = wb_q.size() - 1; i >= 0; i--)  if (wb_q[i].due > k)  wb_q.delete(i);
    end else if (v && !st && !fl) begin
      e.wreg = rdst ? rd : rt;
      e.rw   = rw && (e.wreg != 5'd0);
      e.asrc = asrc; e.aop = aop; e.rs = rs; e.rt = rt;
      e.due = k + 1; ex_q.push_back(e);
      e.due = k + 2; mem_q.push_back(e);
      e.due = k + 3; wb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Monitor: every cycle, pops whatever is due in each stage; an empty slot means a bubble.
  always @(negedge clk) begin
    exp_t       e_ex, e_mem, e_wb;
    bit         h_ex, h_mem, h_wb;
    logic       m_rw, w_rw;
    logic [4:0] m_wr, w_wr, x_rs, x_rt;
    if (prev_rst) begin
      started     = 1;
      exp_retired = '0;
    end
    if (started) begin
      h_ex = 0; h_mem = 0; h_wb = 0;
      if (ex_q.size() > 0 && ex_q[0].due <= cyc) begin
        e_ex = ex_q.pop_front(); h_ex = 1; chk("ex_due", e_ex.due, cyc);
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        e_mem = mem_q.pop_front(); h_mem = 1; chk("mem_due", e_mem.due, cyc);
      end
      if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
        e_wb = wb_q.pop_front(); h_wb = 1; chk("wb_due", e_wb.due, cyc);
      end
      chk("ex_valid",  ex_valid_o,    h_ex);
      chk("ex_alusrc", ex_ALUSrc_o,   h_ex ? e_ex.asrc : 1'b0);
      chk("ex_aluop",  ex_ALUOp_o,    h_ex ? e_ex.aop  : 2'b00);
      chk("ex_wreg",   ex_WriteReg_o, h_ex ? e_ex.wreg : 5'd0);
      m_rw = h_mem ? e_mem.rw   : 1'b0;
      m_wr = h_mem ? e_mem.wreg : 5'd0;
      w_rw = h_wb  ? e_wb.rw    : 1'b0;
      w_wr = h_wb  ? e_wb.wreg  : 5'd0;
      x_rs = h_ex  ? e_ex.rs    : 5'd0;
      x_rt = h_ex  ? e_ex.rt    : 5'd0;
      chk("mem_rw",   mem_RegWrite_o, m_rw);
      chk("mem_wreg", mem_WriteReg_o, m_wr);
      chk("wb_rw",    wb_RegWrite_o,  w_rw);
      chk("wb_wreg",  wb_WriteReg_o,  w_wr);
      chk("retired",  retired_o,      exp_retired);
`ifdef CTRL_PIPE_FORWARD_EN
      chk("fwd_a", ForwardA_o, fwd_model(x_rs, m_rw, m_wr, w_rw, w_wr));
      chk("fwd_b", ForwardB_o, fwd_model(x_rt, m_rw, m_wr, w_rw, w_wr));
`endif
      if (h_wb) exp_retired = exp_retired + 32'd1;
    end
    prev_rst = rst_i;
  end

  initial begin
    bit         have_p;
    bit         p_rdst, p_asrc, p_rw;
    logic [1:0] p_aop;
    logic [4:0] p_rs, p_rt, p_rd;

    have_p = 0;
    p_rdst = 0; p_asrc = 0; p_rw = 0; p_aop = 2'b00; p_rs = '0; p_rt = '0; p_rd = '0;
    rst_i = 1; valid_i = 0; RegDst_i = 0; ALUSrc_i = 0; RegWrite_i = 0; ALUOp_i = 2'b00;
    Rs_i = '0; Rt_i = '0; Rd_i = '0; stall_i = 0; flush_i = 0;

    issue(1, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0);
    issue(1, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);

    // R-type writing $3 (Rd) rather than $5 (Rt)
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd5, 5'd3, 0, 0);
    idle(4);

    // ADDI targeting $0: write suppressed but still retires
    issue(0, 1, 0, 1, 1, 2'b00, 5'd2, 5'd0, 5'd9, 0, 0);
    idle(4);

    // Stream with a one-cycle stall on the third instruction (which is re-presented)
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd6, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd7, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd8, 1, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd8, 0, 0);
    issue(0, 1, 1, 1, 1, 2'b00, 5'd1, 5'd2, 5'd10, 0, 0);
    idle(4);

    // Stall and flush together: dropped instruction, then a different one
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd11, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd12, 1, 1);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd13, 0, 0);
    idle(4);

    // Reset with three instructions in flight
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd14, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd15, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd16, 0, 0);
    issue(1, 1, 1, 0, 1, 2'b11, 5'd1, 5'd2, 5'd17, 0, 0);
    idle(4);

    // Forwarding scenarios: MEM hit, WB hit through a bubble, both stages matching
    issue(0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd2, 5'd4, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd4, 5'd9, 5'd20, 0, 0);
    idle(4);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd2, 5'd4, 0, 0);
    idle(1);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd4, 5'd9, 5'd21, 0, 0);
    idle(4);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd1, 5'd2, 5'd4, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd3, 5'd2, 5'd4, 0, 0);
    issue(0, 1, 1, 0, 1, 2'b00, 5'd4, 5'd4, 5'd22, 0, 0);
    idle(4);

    // Unassigned ALUOp codes travel unchanged
    issue(0, 1, 0, 1, 0, 2'b01, 5'd1, 5'd2, 5'd3, 0, 0);
    issue(0, 1, 0, 0, 1, 2'b10, 5'd1, 5'd2, 5'd3, 0, 0);
    idle(4);

    // Random traffic; a stalled instruction is held and re-presented
    for (int n = 0; n < 600; n++) begin
      bit r, st, fl, v;
      if (!have_p) begin
        p_rdst = 1'($urandom); p_asrc = 1'($urandom); p_rw = 1'($urandom);
        p_aop  = 2'($urandom);
        p_rs = 5'($urandom_range(0, 7)); p_rt = 5'($urandom_range(0, 7));
        p_rd = 5'($urandom_range(0, 7));
        have_p = 1;
      end
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 9) == 0);
      issue(r, v, p_rdst, p_asrc, p_rw, p_aop, p_rs, p_rt, p_rd, st, fl);
      if (!v || r || fl || !st) have_p = 0;
    end

    idle(6);
    chk("drain", ex_q.size() + mem_q.size() + wb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, misses);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port valid_i, input, 1, ID-stage instruction valid.
REQ-005 SHALL have ports RegDst_i, ALUSrc_i and RegWrite_i (input, 1 each) and ALUOp_i (input, 2), the decoded ID-stage control bits.
REQ-006 SHALL have ports Rs_i, Rt_i and Rd_i, input, REG_W each, ID-stage register fields.
REQ-007 SHALL have port stall_i, input, 1, insert bubble into EX; upstream holds.
REQ-008 SHALL have port flush_i, input, 1, discard the ID-stage instruction.
REQ-009 SHALL have ports ex_valid_o (1), ex_ALUSrc_o (1), ex_ALUOp_o (2) and ex_WriteReg_o (REG_W), all outputs, EX-stage controls.
REQ-010 SHALL have ports mem_RegWrite_o (1) and mem_WriteReg_o (REG_W), both outputs, MEM-stage write intent.
REQ-011 SHALL have ports wb_RegWrite_o (1) and wb_WriteReg_o (REG_W), both outputs, register-file write enable/address.
REQ-012 SHALL have port retired_o, output, 32, count of retired valid instructions.

Function
REQ-013 SHALL implement three control registers ID/EX, EX/MEM and MEM/WB, each holding valid, RegWrite, WriteReg, plus ALUSrc/ALUOp in ID/EX only.
REQ-014 SHALL resolve WriteReg at ID/EX capture: RegDst_i=1 selects Rd_i, else Rt_i.
REQ-015 SHALL force captured RegWrite to 0 when the resolved WriteReg is 0.
REQ-016 SHALL capture a bubble (valid=0, RegWrite=0, ALUSrc=0, ALUOp=00, WriteReg=0) into ID/EX when valid_i=0, stall_i=1 or flush_i=1; flush_i and stall_i together also yield one bubble.
REQ-017 SHALL advance EX/MEM and MEM/WB every cycle unconditionally; stall_i and flush_i SHALL not affect them.
REQ-018 SHALL have latency of exactly 1 cycle from ID to EX, 2 to MEM and 3 to WB for each non-bubble instruction.
REQ-019 SHALL gate every stage output RegWrite with that stage's valid bit.
REQ-020 SHALL increment retired_o by 1 in each cycle in which MEM/WB valid=1, wrapping from 0xFFFFFFFF to 0.
REQ-021 SHALL pass ALUOp 01/10 (illegal) through unchanged; decoding them is not this block's role.

Reset
REQ-022 SHALL, on any clock edge with rst_i=1 (including mid-operation), clear all three registers to bubble and retired_o to 0; all outputs read 0 the following cycle.
REQ-023 SHALL give rst_i priority over stall_i, flush_i and valid_i.

Configuration
REQ-024 SHALL recognise the macro CTRL_PIPE_FORWARD_EN; when defined, it SHALL add ForwardA_o and ForwardB_o (output, 2 each) and register Rs/Rt in ID/EX.
REQ-025 SHALL, with CTRL_PIPE_FORWARD_EN defined, set ForwardA_o=10 when mem_RegWrite_o=1 and mem_WriteReg_o equals the EX Rs; else 01 when wb_RegWrite_o=1 and wb_WriteReg_o equals the EX Rs; else 00; ForwardB_o SHALL follow the same rule using EX Rt; both SHALL be combinational and MEM SHALL take priority.
REQ-026 SHALL, without CTRL_PIPE_FORWARD_EN, omit the forwarding ports and Rs/Rt storage entirely.

Structure
REQ-027 SHALL place the ALUOp encodings (ADD=00, RTYPE=11), the forward-select encodings (NONE=00, WB=01, MEM=10) and the stage-bundle struct typedef in the shared package ctrl_pkg.
REQ-028 SHALL implement each stage register as one sub-module, ctrl_stage_reg (bundle, load, bubble), instantiated three times.

Verification
REQ-029 SHALL test: R-type with Rd=3, Rt=5, RegDst=1, RegWrite=1 -> ex_WriteReg_o=3 in cycle 1; wb_RegWrite_o=1 and wb_WriteReg_o=3 in cycle 3; retired_o=1 in cycle 4.
REQ-030 SHALL test: ADDI with Rt=0, RegWrite=1 -> wb_RegWrite_o=0 in cycle 3; retired_o still increments.
REQ-031 SHALL test: stall_i=1 for 1 cycle during an instruction stream -> exactly one bubble appears in EX, MEM and WB in successive cycles, and older instructions are undisturbed.
REQ-032 SHALL test: stall_i=1 and flush_i=1 in the same cycle -> one bubble only, with no duplicate instruction.
REQ-033 SHALL test: rst_i asserted with 3 instructions in flight -> all outputs are 0 next cycle and no wb write occurs.
REQ-034 SHALL test, with CTRL_PIPE_FORWARD_EN defined: back-to-back add $4 then add using Rs=$4 -> ForwardA_o=10; with one intervening bubble -> ForwardA_o=01; with both MEM and WB matching -> ForwardA_o=10.
